// File: rtl/usb_slave_access_arbiter.sv
// Two-way arbiter in front of the USB slave decoder: serialises AXI-side writes and
// host-side reads, sequences the decoder command, write strobes and read-data capture.
module usb_slave_access_arbiter #(
  parameter int RD_LATENCY = 2,
  parameter bit ADDR_CHECK = 1'b1
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        i_wr_req,
  input  logic [31:0] i_wr_addr,
  input  logic [31:0] i_wr_data,
  output logic        o_wr_ack,
  output logic        o_wr_err,
  input  logic        i_rd_req,
  input  logic [31:0] i_rd_addr,
  output logic        o_rd_valid,
  input  logic        i_rd_ready,
  output logic [31:0] o_rd_data,
  output logic        o_rd_err,
  output logic [31:0] o_dec_addr,
  output logic [1:0]  o_dec_read_en,
  output logic        o_mem_we,
  output logic        o_reg_we,
  output logic [31:0] o_wdata,
  input  logic [31:0] i_mem_rdata,
  input  logic [31:0] i_reg_rdata,
  output logic [2:0]  o_dbg_state
);

  // Handshakes: a request stays high with stable address/data until its response;
  // wr_ack is a 1-cycle pulse, rd_valid holds with stable data until rd_ready is sampled high.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WR_ISSUE  = 3'd1,
    WR_COMMIT = 3'd2,
    RD_ISSUE  = 3'd3,
    RD_WAIT   = 3'd4,
    RD_RESP   = 3'd5,
    ERR_RESP  = 3'd6
  } state_t;

  localparam logic [2:0] LAST_CNT = 3'(RD_LATENCY - 1);

  state_t      r_state;
  logic        r_last_wr;
  logic        r_err_wr;
  logic [2:0]  r_cnt;
  logic        r_wr_ack;
  logic        r_wr_err;
  logic        r_rd_valid;
  logic [31:0] r_rd_data;
  logic        r_rd_err;
  logic [31:0] r_dec_addr;
  logic [1:0]  r_dec_read_en;
  logic        r_mem_we;
  logic        r_reg_we;
  logic [31:0] r_wdata;

  logic w_wr_oor;
  logic w_rd_oor;
  logic w_grant_wr;

  assign w_wr_oor   = ADDR_CHECK & (|i_wr_addr[31:11]);
  assign w_rd_oor   = ADDR_CHECK & (|i_rd_addr[31:11]);
  // Under contention the side that did not win last time gets the grant.
  assign w_grant_wr = i_wr_req & (~i_rd_req | ~r_last_wr);

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      r_state       <= IDLE;
      r_last_wr     <= 1'b0;
      r_err_wr      <= 1'b0;
      r_cnt         <= 3'd0;
      r_wr_ack      <= 1'b0;
      r_wr_err      <= 1'b0;
      r_rd_valid    <= 1'b0;
      r_rd_data     <= 32'd0;
      r_rd_err      <= 1'b0;
      r_dec_addr    <= 32'd0;
      r_dec_read_en <= 2'b00;
      r_mem_we      <= 1'b0;
      r_reg_we      <= 1'b0;
      r_wdata       <= 32'd0;
    end else begin
      r_wr_ack      <= 1'b0;
      r_wr_err      <= 1'b0;
      r_mem_we      <= 1'b0;
      r_reg_we      <= 1'b0;
      r_dec_read_en <= 2'b00;
      case (r_state)
        IDLE: begin
          if (i_wr_req || i_rd_req) begin
            if (w_grant_wr) begin
              r_last_wr <= 1'b1;
              if (w_wr_oor) begin
                r_state  <= ERR_RESP;
                r_err_wr <= 1'b1;
                r_wr_ack <= 1'b1;
                r_wr_err <= 1'b1;
              end else begin
                r_state       <= WR_ISSUE;
                r_dec_addr    <= i_wr_addr;
                r_wdata       <= i_wr_data;
                r_dec_read_en <= 2'b10;
              end
            end else begin
              r_last_wr <= 1'b0;
              if (w_rd_oor) begin
                r_state    <= ERR_RESP;
                r_err_wr   <= 1'b0;
                r_rd_valid <= 1'b1;
                r_rd_err   <= 1'b1;
                r_rd_data  <= 32'd0;
              end else begin
                r_state       <= RD_ISSUE;
                r_dec_addr    <= i_rd_addr;
                r_dec_read_en <= 2'b01;
              end
            end
          end
        end
        WR_ISSUE: begin
          // Decoder has registered the address by now, so the strobe lands on the commit cycle.
          r_state  <= WR_COMMIT;
          r_mem_we <= ~r_dec_addr[10];
          r_reg_we <= r_dec_addr[10];
          r_wr_ack <= 1'b1;
        end
        WR_COMMIT: r_state <= IDLE;
        RD_ISSUE: begin
          r_state  <= RD_WAIT;
          r_cnt    <= 3'd0;
          r_rd_err <= 1'b0;
        end
        RD_WAIT: begin
          if (r_cnt == LAST_CNT) begin
            r_rd_data  <= r_dec_addr[10] ? i_reg_rdata : i_mem_rdata;
            r_rd_valid <= 1'b1;
            r_state    <= RD_RESP;
          end else begin
            r_cnt <= r_cnt + 3'd1;
          end
        end
        RD_RESP: begin
          if (i_rd_ready) begin
            r_rd_valid <= 1'b0;
            r_state    <= IDLE;
          end
        end
        ERR_RESP: begin
          if (r_err_wr) begin
            r_state <= IDLE;
          end else if (i_rd_ready) begin
            r_rd_valid <= 1'b0;
            r_rd_err   <= 1'b0;
            r_state    <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_wr_ack      = r_wr_ack;
  assign o_wr_err      = r_wr_err;
  assign o_rd_valid    = r_rd_valid;
  assign o_rd_data     = r_rd_data;
  assign o_rd_err      = r_rd_err;
  assign o_dec_addr    = r_dec_addr;
  assign o_dec_read_en = r_dec_read_en;
  assign o_mem_we      = r_mem_we;
  assign o_reg_we      = r_reg_we;
  assign o_wdata       = r_wdata;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_usb_slave_access_arbiter.sv
// Directed bench for usb_slave_access_arbiter (RD_LATENCY=2, ADDR_CHECK=1); outputs are
// sampled 1 ns after each rising edge, inputs driven at the same point.
module tb_usb_slave_access_arbiter;

  logic        Clk;
  logic        Rst;
  logic        i_wr_req;
  logic [31:0] i_wr_addr;
  logic [31:0] i_wr_data;
  logic        o_wr_ack;
  logic        o_wr_err;
  logic        i_rd_req;
  logic [31:0] i_rd_addr;
  logic        o_rd_valid;
  logic        i_rd_ready;
  logic [31:0] o_rd_data;
  logic        o_rd_err;
  logic [31:0] o_dec_addr;
  logic [1:0]  o_dec_read_en;
  logic        o_mem_we;
  logic        o_reg_we;
  logic [31:0] o_wdata;
  logic [31:0] i_mem_rdata;
  logic [31:0] i_reg_rdata;
  logic [2:0]  o_dbg_state;

  int n_checks;
  int n_fail;

  usb_slave_access_arbiter #(.RD_LATENCY(2), .ADDR_CHECK(1'b1)) dut (
    .Clk(Clk), .Rst(Rst),
    .i_wr_req(i_wr_req), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data),
    .o_wr_ack(o_wr_ack), .o_wr_err(o_wr_err),
    .i_rd_req(i_rd_req), .i_rd_addr(i_rd_addr), .o_rd_valid(o_rd_valid),
    .i_rd_ready(i_rd_ready), .o_rd_data(o_rd_data), .o_rd_err(o_rd_err),
    .o_dec_addr(o_dec_addr), .o_dec_read_en(o_dec_read_en),
    .o_mem_we(o_mem_we), .o_reg_we(o_reg_we), .o_wdata(o_wdata),
    .i_mem_rdata(i_mem_rdata), .i_reg_rdata(i_reg_rdata),
    .o_dbg_state(o_dbg_state)
  );

  // clock / reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic do_reset();
    Rst = 1'b0;
    tick();
    tick();
    Rst = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_wr_ack"}, 32'(o_wr_ack), 32'd0);
    check_eq({tag, "_wr_err"}, 32'(o_wr_err), 32'd0);
    check_eq({tag, "_rd_valid"}, 32'(o_rd_valid), 32'd0);
    check_eq({tag, "_rd_data"}, o_rd_data, 32'd0);
    check_eq({tag, "_rd_err"}, 32'(o_rd_err), 32'd0);
    check_eq({tag, "_dec_addr"}, o_dec_addr, 32'd0);
    check_eq({tag, "_dec_en"}, 32'(o_dec_read_en), 32'd0);
    check_eq({tag, "_mem_we"}, 32'(o_mem_we), 32'd0);
    check_eq({tag, "_reg_we"}, 32'(o_reg_we), 32'd0);
    check_eq({tag, "_wdata"}, o_wdata, 32'd0);
    check_eq({tag, "_state"}, 32'(o_dbg_state), 32'd0);
  endtask

  logic [1:0] exp_pat [12] = '{2'b10, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00,
                               2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b01};

  initial begin
    logic [1:0] prev_en;
    n_checks = 0;
    n_fail = 0;
    i_wr_req = 0; i_wr_addr = 0; i_wr_data = 0;
    i_rd_req = 0; i_rd_addr = 0; i_rd_ready = 0;
    i_mem_rdata = 32'hAAAA5555; i_reg_rdata = 32'h5555AAAA;
    do_reset();
    check_all_zero("reset");

    // Contention straight after reset: write first, then alternate.
    i_wr_req = 1; i_wr_addr = 32'h10; i_wr_data = 32'h0000_1111;
    i_rd_req = 1; i_rd_addr = 32'h0;  i_rd_ready = 1;
    i_mem_rdata = 32'h1111_2222;
    prev_en = 2'b00;
    for (int i = 1; i <= 12; i++) begin
      tick();
      check_eq($sformatf("cont_en_c%0d", i), 32'(o_dec_read_en), 32'(exp_pat[i-1]));
      check_eq($sformatf("cont_ack_c%0d", i), 32'(o_wr_ack), 32'((i == 2) || (i == 10)));
      check_eq($sformatf("cont_val_c%0d", i), 32'(o_rd_valid), 32'(i == 7));
      if (i == 7) check_eq("cont_rdata", o_rd_data, 32'h1111_2222);
      check_eq($sformatf("cont_turn_c%0d", i),
               32'((prev_en != 2'b00) && (o_dec_read_en != 2'b00)), 32'd0);
      prev_en = o_dec_read_en;
    end
    i_wr_req = 0; i_rd_req = 0;
    for (int i = 0; i < 8; i++) tick();
    check_eq("cont_idle", 32'(o_dbg_state), 32'd0);

    // Write only to packet memory.
    i_wr_req = 1; i_wr_addr = 32'h0000_0010; i_wr_data = 32'hDEAD_BEEF;
    tick();
    check_eq("wr_c1_en", 32'(o_dec_read_en), 32'h2);
    check_eq("wr_c1_addr", o_dec_addr, 32'h10);
    check_eq("wr_c1_ack", 32'(o_wr_ack), 32'd0);
    tick();
    check_eq("wr_c2_en", 32'(o_dec_read_en), 32'd0);
    check_eq("wr_c2_mem_we", 32'(o_mem_we), 32'd1);
    check_eq("wr_c2_reg_we", 32'(o_reg_we), 32'd0);
    check_eq("wr_c2_wdata", o_wdata, 32'hDEAD_BEEF);
    check_eq("wr_c2_ack", 32'(o_wr_ack), 32'd1);
    check_eq("wr_c2_err", 32'(o_wr_err), 32'd0);
    i_wr_req = 0;
    tick();
    check_eq("wr_c3_ack", 32'(o_wr_ack), 32'd0);
    check_eq("wr_c3_mem_we", 32'(o_mem_we), 32'd0);

    // Write to register file.
    i_wr_req = 1; i_wr_addr = 32'h0000_0408; i_wr_data = 32'h0BAD_F00D;
    tick();
    tick();
    check_eq("wreg_mem_we", 32'(o_mem_we), 32'd0);
    check_eq("wreg_reg_we", 32'(o_reg_we), 32'd1);
    check_eq("wreg_addr", o_dec_addr, 32'h408);
    i_wr_req = 0;
    tick();

    // Register read, RD_LATENCY=2.
    i_rd_req = 1; i_rd_addr = 32'h0000_0404; i_rd_ready = 1;
    i_reg_rdata = 32'h1234_5678; i_mem_rdata = 32'hAAAA5555;
    tick();
    check_eq("rreg_c1_en", 32'(o_dec_read_en), 32'h1);
    check_eq("rreg_c1_addr", o_dec_addr, 32'h404);
    tick();
    check_eq("rreg_c2_val", 32'(o_rd_valid), 32'd0);
    tick();
    check_eq("rreg_c3_val", 32'(o_rd_valid), 32'd0);
    tick();
    check_eq("rreg_c4_val", 32'(o_rd_valid), 32'd1);
    check_eq("rreg_c4_data", o_rd_data, 32'h1234_5678);
    check_eq("rreg_c4_err", 32'(o_rd_err), 32'd0);
    i_rd_req = 0;
    tick();
    check_eq("rreg_c5_val", 32'(o_rd_valid), 32'd0);

    // Memory read.
    i_rd_req = 1; i_rd_addr = 32'h0000_0020; i_mem_rdata = 32'hCAFE_F00D;
    for (int i = 0; i < 4; i++) tick();
    check_eq("rmem_c4_val", 32'(o_rd_valid), 32'd1);
    check_eq("rmem_c4_data", o_rd_data, 32'hCAFE_F00D);
    i_rd_req = 0;
    tick();

    // Out-of-range write.
    i_wr_req = 1; i_wr_addr = 32'h0000_0800; i_wr_data = 32'h5A5A_5A5A;
    tick();
    check_eq("oorw_ack", 32'(o_wr_ack), 32'd1);
    check_eq("oorw_err", 32'(o_wr_err), 32'd1);
    check_eq("oorw_en", 32'(o_dec_read_en), 32'd0);
    check_eq("oorw_mem_we", 32'(o_mem_we), 32'd0);
    check_eq("oorw_reg_we", 32'(o_reg_we), 32'd0);
    i_wr_req = 0;
    tick();
    check_eq("oorw_c2_ack", 32'(o_wr_ack), 32'd0);
    check_eq("oorw_c2_mem_we", 32'(o_mem_we), 32'd0);

    // Out-of-range read, held under backpressure for one cycle.
    i_rd_req = 1; i_rd_addr = 32'h0000_1000; i_rd_ready = 0;
    tick();
    check_eq("oorr_val", 32'(o_rd_valid), 32'd1);
    check_eq("oorr_err", 32'(o_rd_err), 32'd1);
    check_eq("oorr_data", o_rd_data, 32'd0);
    check_eq("oorr_en", 32'(o_dec_read_en), 32'd0);
    i_rd_req = 0;
    tick();
    check_eq("oorr_hold", 32'(o_rd_valid), 32'd1);
    i_rd_ready = 1;
    tick();
    check_eq("oorr_clear", 32'(o_rd_valid), 32'd0);
    check_eq("oorr_err_clear", 32'(o_rd_err), 32'd0);

    // Backpressure with a pending write.
    i_rd_req = 1; i_rd_addr = 32'h0000_0404; i_rd_ready = 0;
    i_reg_rdata = 32'h0BAD_CAFE;
    tick();
    i_wr_req = 1; i_wr_addr = 32'h0000_0014; i_wr_data = 32'h7777_0000;
    tick();
    tick();
    tick();
    check_eq("bp_c4_val", 32'(o_rd_valid), 32'd1);
    check_eq("bp_c4_data", o_rd_data, 32'h0BAD_CAFE);
    i_rd_req = 0;
    i_reg_rdata = 32'hFFFF_0000;
    for (int i = 5; i <= 8; i++) begin
      tick();
      check_eq($sformatf("bp_c%0d_val", i), 32'(o_rd_valid), 32'd1);
      check_eq($sformatf("bp_c%0d_data", i), o_rd_data, 32'h0BAD_CAFE);
      check_eq($sformatf("bp_c%0d_en", i), 32'(o_dec_read_en), 32'd0);
    end
    i_rd_ready = 1;
    tick();
    check_eq("bp_c9_val", 32'(o_rd_valid), 32'd0);
    check_eq("bp_c9_en", 32'(o_dec_read_en), 32'd0);
    tick();
    check_eq("bp_c10_en", 32'(o_dec_read_en), 32'h2);
    check_eq("bp_c10_addr", o_dec_addr, 32'h14);
    tick();
    check_eq("bp_c11_ack", 32'(o_wr_ack), 32'd1);
    i_wr_req = 0;
    tick();

    // Reset during RD_WAIT, then contention grants write first.
    i_rd_req = 1; i_rd_addr = 32'h0000_0020;
    tick();
    tick();
    check_eq("rst_in_wait", 32'(o_dbg_state), 32'd4);
    i_wr_req = 1; i_wr_addr = 32'h0000_0018;
    Rst = 0;
    tick();
    check_all_zero("midrst");
    Rst = 1;
    tick();
    check_eq("midrst_grant_en", 32'(o_dec_read_en), 32'h2);
    check_eq("midrst_grant_addr", o_dec_addr, 32'h18);
    i_wr_req = 0; i_rd_req = 0;
    for (int i = 0; i < 10; i++) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
